// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Sits beside the EX-stage ALU; one op per start pulse, fixed latency per op class.
// Optional multiply-accumulate ops (7..10) are compiled in when MDU_MACC_EN is defined.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               long_op;

  // Full-width signed and unsigned products of the incoming operands
  always_comb begin
    prod_s = $signed({{WIDTH{inA[WIDTH-1]}}, inA}) * $signed({{WIDTH{inB[WIDTH-1]}}, inB});
    prod_u = {{WIDTH{1'b0}}, inA} * {{WIDTH{1'b0}}, inB};
  end

  // Quotient/remainder, with divide-by-zero and signed overflow resolved explicitly
  always_comb begin
    div_quo = '0;
    div_rem = '0;
    if (inB == '0) begin
      div_quo = '1;
      div_rem = inA;
    end else if (op == OP_DIV) begin
      if (inA == MIN_NEG && inB == '1) begin
        div_quo = MIN_NEG;
        div_rem = '0;
      end else begin
        div_quo = WIDTH'($signed(inA) / $signed(inB));
        div_rem = WIDTH'($signed(inA) % $signed(inB));
      end
    end else begin
      div_quo = inA / inB;
      div_rem = inA % inB;
    end
  end

  // Decode which op codes occupy the unit for multiple cycles
  always_comb begin
    long_op = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MDU_MACC_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  // Accept/commit control: result is precomputed at accept and held until the counter expires
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (state_q == ST_BUSY) begin
      if (cnt_q == CNT_ONE) begin
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          cnt_d   = MULT_N;
          state_d = ST_BUSY;
        end
        OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          cnt_d   = MULT_N;
          state_d = ST_BUSY;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi_d = div_rem;
          pend_lo_d = div_quo;
          cnt_d     = DIV_N;
          state_d   = ST_BUSY;
        end
        OP_MTHI: hi_d = inA;
        OP_MTLO: lo_d = inA;
`ifdef MDU_MACC_EN
        OP_MADD: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
          cnt_d   = MULT_N;
          state_d = ST_BUSY;
        end
        OP_MADDU: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
          cnt_d   = MULT_N;
          state_d = ST_BUSY;
        end
        OP_MSUB: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
          cnt_d   = MULT_N;
          state_d = ST_BUSY;
        end
        OP_MSUBU: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_u;
          cnt_d   = MULT_N;
          state_d = ST_BUSY;
        end
`endif
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Outputs; stall_req also covers the accept cycle so EX holds before busy rises
  always_comb begin
    busy      = (state_q == ST_BUSY);
    done      = done_q;
    hi        = hi_q;
    lo        = lo_q;
    stall_req = (state_q == ST_BUSY) | (start & long_op);
  end

endmodule
